// File: rtl/mux_arb_n.sv
// mux_arb_n: registered N-channel, W-bit multiplexer with valid/ready
// handshakes and built-in arbitration into a single-entry output register.
//
// Ports:
//   clk        in   1            rising-edge clock
//   rst        in   1            synchronous active-high reset
//   in_valid   in   N            per-channel word offered
//   in_ready   out  N            per-channel word accepted (one-hot or zero)
//   in_data    in   N*W          channel i at [i*W +: W]
//   out_valid  out  1            output register holds a word
//   out_ready  in   1            consumer accepts the word
//   out_data   out  W            held word
//   out_sel    out  $clog2(N)    channel that supplied out_data
//
// Build option: define MUX_ARB_FIXED_PRIORITY_EN for fixed priority
// (lowest valid index wins, no round-robin pointer). Default is round-robin.

module mux_arb_n #(
    parameter int N = 4,
    parameter int W = 32,
    localparam int SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic [N*W-1:0]  in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_data,
    output logic [SW-1:0]   out_sel
);

    logic [W-1:0]  ch_data [N];
    logic          space;
    logic          grant_valid;
    logic [SW-1:0] grant_idx;
    logic          xfer;

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign ch_data[i] = in_data[i*W +: W];
    end

    assign space = ~out_valid | out_ready;

`ifdef MUX_ARB_FIXED_PRIORITY_EN

    // Scan from the top down so the lowest valid index is written last.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (in_valid[SW'(k)]) begin
                grant_valid = 1'b1;
                grant_idx   = SW'(k);
            end
        end
    end

`else

    logic [SW-1:0] ptr;
    logic [SW:0]   sum;
    logic [SW-1:0] idx;

    // Scan offsets from N-1 down to 0 so the channel closest to ptr
    // (smallest offset) is written last and wins. One extra bit in sum
    // keeps the modulo-N wrap correct for non-power-of-two N.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        sum         = '0;
        idx         = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (SW+1)'(k);
            if (sum >= (SW+1)'(N)) begin
                sum = sum - (SW+1)'(N);
            end
            idx = sum[SW-1:0];
            if (in_valid[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (xfer) begin
            ptr <= (grant_idx == SW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

`endif

    assign xfer = ~rst & space & grant_valid;

    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready = N'(1) << grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= ch_data[grant_idx];
            out_sel   <= grant_idx;
        end else if (out_valid & out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_arb_n.sv
// tb_mux_arb_n: directed self-checking bench for mux_arb_n (N=4, W=32).
// Round-robin checks by default; fixed-priority checks when the macro is set.

module tb_mux_arb_n;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [N*W-1:0] in_data;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [1:0]     out_sel;

    int vectors = 0;
    int errors  = 0;

    mux_arb_n #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v,
                           input logic [1:0] s, input logic [31:0] d);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".out_sel"}, 32'(out_sel), 32'(s));
        chk({tag, ".out_data"}, out_data, d);
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        in_valid  = 4'b1111;
        for (int i = 0; i < N; i++) begin
            in_data[i*W +: W] = 32'hA0 + 32'(i);
        end

        // reset held two cycles with everything requesting
        for (int c = 0; c < 2; c++) begin
            tick();
            chk_out("reset", 1'b0, 2'd0, 32'h0);
            chk("reset.in_ready", 32'(in_ready), 32'h0);
        end
        rst = 1'b0;
        #1;
        chk("post_reset.in_ready", 32'(in_ready), 32'b0001);

`ifdef MUX_ARB_FIXED_PRIORITY_EN

        tick();
        chk_out("fp_first", 1'b1, 2'd0, 32'hA0);
        in_valid = 4'b1010;
        #1;
        for (int c = 0; c < 6; c++) begin
            chk("fp.in_ready", 32'(in_ready), 32'b0010);
            tick();
            chk_out("fp", 1'b1, 2'd1, 32'hA1);
        end
        in_valid = 4'b1000;
        #1;
        chk("fp_only3.in_ready", 32'(in_ready), 32'b1000);
        tick();
        chk_out("fp_only3", 1'b1, 2'd3, 32'hA3);

`else

        // saturated round-robin: 0,1,2,3,0,1
        for (int c = 0; c < 6; c++) begin
            tick();
            chk_out("rr", 1'b1, 2'(c % 4), 32'hA0 + 32'(c % 4));
            chk("rr.in_ready", 32'(in_ready), 32'(4'b0001 << ((c + 1) % 4)));
        end

        // backpressure on channel 2 (ptr is 2 here)
        in_valid = 4'b0100;
        in_data[2*W +: W] = 32'h1234;
        #1;
        chk("bp_load.in_ready", 32'(in_ready), 32'b0100);
        tick();
        chk_out("bp_load", 1'b1, 2'd2, 32'h1234);
        out_ready = 1'b0;
        in_data[2*W +: W] = 32'h5678;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("bp_hold.in_ready", 32'(in_ready), 32'h0);
            tick();
            chk_out("bp_hold", 1'b1, 2'd2, 32'h1234);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release.in_ready", 32'(in_ready), 32'b0100);
        tick();
        chk_out("bp_release", 1'b1, 2'd2, 32'h5678);

        // sparse: ptr=3, only channel 1 -> wrap to 1, ptr becomes 2
        in_valid = 4'b0010;
        in_data[1*W +: W] = 32'h1111;
        #1;
        chk("sparse.in_ready", 32'(in_ready), 32'b0010);
        tick();
        chk_out("sparse", 1'b1, 2'd1, 32'h1111);
        in_valid = 4'b1111;
        #1;
        chk("sparse_ptr.in_ready", 32'(in_ready), 32'b0100);

        // mid-operation reset while FULL
        in_valid = 4'b0100;
        in_data[2*W +: W] = 32'hDEADBEEF;
        tick();
        chk_out("full_dead", 1'b1, 2'd2, 32'hDEADBEEF);
        rst = 1'b1;
        in_valid = 4'b1111;
        #1;
        chk("mid_rst.in_ready", 32'(in_ready), 32'h0);
        tick();
        chk_out("mid_rst", 1'b0, 2'd0, 32'h0);
        rst = 1'b0;
        in_valid = 4'b0000;
        tick();
        chk_out("idle", 1'b0, 2'd0, 32'h0);
        in_valid = 4'b1111;
        #1;
        chk("rst_ptr.in_ready", 32'(in_ready), 32'b0001);

        // load then drain with nothing requesting
        in_valid = 4'b0001;
        tick();
        chk_out("drain_load", 1'b1, 2'd0, 32'hA0);
        in_valid = 4'b0000;
        #1;
        chk("drain.in_ready", 32'(in_ready), 32'h0);
        tick();
        chk("drain.out_valid", 32'(out_valid), 32'h0);

`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
